// File: rtl/prefetch_queue_if.sv
// Signal bundle between the prefetch queue, the instruction bus and the consumer.
// The master modport is the queue's view; the slave modport is its environment.
interface prefetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [29:0]      bus_address;
  logic             bus_read;
  logic             bus_grant;
  logic             bus_ready;
  logic             bus_error;
  logic [31:0]      bus_data_in;
  logic             jump;
  logic [31:0]      jump_address;
  logic             instr_valid;
  logic [31:0]      instr_data;
  logic [31:0]      instr_address;
  logic             instr_take;
  logic [CNT_W-1:0] count;
  logic             fault;

  modport master (
    output bus_address, bus_read, instr_valid, instr_data, instr_address, count, fault,
    input  bus_grant, bus_ready, bus_error, bus_data_in, jump, jump_address, instr_take
  );

  modport slave (
    input  bus_address, bus_read, instr_valid, instr_data, instr_address, count, fault,
    output bus_grant, bus_ready, bus_error, bus_data_in, jump, jump_address, instr_take
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: sequential word fetches with one read outstanding,
// a DEPTH-entry FIFO of {instruction, address}, jump redirect and bus-error fault stop.
module prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input logic              clock,
  input logic              reset,
  prefetch_queue_if.master pq
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DISCARD,
    FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetchPc_q, fetchPc_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fault_q, fault_d;
  logic             push;
  logic             pop;
  logic [31:0]      jumpTarget;

  logic [31:0] dataMem_q [DEPTH];
  logic [31:0] addrMem_q [DEPTH];

  assign jumpTarget = pq.jump_address & 32'hFFFF_FFFC;

  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    fault_d   = fault_q;
    push      = 1'b0;
    pop       = pq.instr_take && (count_q != '0) && !pq.jump;

    case (state_q)
      IDLE: begin
        if (pq.bus_grant && !fault_q && !pq.jump && (count_q < FULL)) begin
          state_d = READ;
        end
      end
      READ: begin
        if (pq.bus_ready) begin
          if (pq.bus_error) begin
            state_d = FAULT;
            fault_d = 1'b1;
          end else begin
            push      = (count_q != FULL);
            fetchPc_d = fetchPc_q + 32'd4;
            state_d   = IDLE;
          end
        end
      end
      DISCARD: begin
        if (pq.bus_ready) begin
          state_d = IDLE;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A jump overrides everything above; a read still in flight must be drained.
    if (pq.jump) begin
      push      = 1'b0;
      fault_d   = 1'b0;
      fetchPc_d = jumpTarget;
      if (((state_q == READ) || (state_q == DISCARD)) && !pq.bus_ready) begin
        state_d = DISCARD;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pq.jump) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      fault_q   <= fault_d;
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      dataMem_q[tail_q] <= pq.bus_data_in;
      addrMem_q[tail_q] <= fetchPc_q;
    end
  end

  assign pq.bus_read      = (state_q == READ);
  assign pq.bus_address   = fetchPc_q[31:2];
  assign pq.instr_valid   = (count_q != '0);
  assign pq.instr_data    = dataMem_q[head_q];
  assign pq.instr_address = addrMem_q[head_q];
  assign pq.count         = count_q;
  assign pq.fault         = fault_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// Directed bench for prefetch_queue: fill, streaming, jumps, grant drop,
// bus error/fault recovery, address wrap and reset abandoning a read.
module tb_prefetch_queue;

  localparam int DEPTH = 4;
  localparam bit ON  = 1'b1;
  localparam bit OFF = 1'b0;

  logic clock = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;

  prefetch_queue_if #(.DEPTH(DEPTH)) pq ();

  prefetch_queue #(
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pq   (pq)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input bit grant, input bit ready, input bit err,
                               input logic [31:0] data, input bit jmp,
                               input logic [31:0] jaddr, input bit take);
    pq.bus_grant    = grant;
    pq.bus_ready    = ready;
    pq.bus_error    = err;
    pq.bus_data_in  = data;
    pq.jump         = jmp;
    pq.jump_address = jaddr;
    pq.instr_take   = take;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] expA;
    int          seen;

    reset           = 1'b1;
    pq.bus_grant    = 1'b0;
    pq.bus_ready    = 1'b0;
    pq.bus_error    = 1'b0;
    pq.bus_data_in  = 32'h0;
    pq.jump         = 1'b0;
    pq.jump_address = 32'h0;
    pq.instr_take   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rst_count", 32'(pq.count), 32'd0);
    checkOutput("rst_valid", 32'(pq.instr_valid), 32'd0);
    checkOutput("rst_busread", 32'(pq.bus_read), 32'd0);
    checkOutput("rst_fault", 32'(pq.fault), 32'd0);
    checkOutput("rst_busaddr", 32'(pq.bus_address), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Fill to DEPTH with a completion every second cycle and no consumer.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      checkOutput("fill_read", 32'(pq.bus_read), 32'd1);
      checkOutput("fill_addr", 32'(pq.bus_address), i);
      applyStimulus(ON, ON, OFF, 32'hA000_0000 + 4 * i, OFF, 32'h0, OFF);
      checkOutput("fill_count", 32'(pq.count), i + 1);
      checkOutput("fill_readlow", 32'(pq.bus_read), 32'd0);
    end
    repeat (3) begin
      applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      checkOutput("full_noread", 32'(pq.bus_read), 32'd0);
    end
    checkOutput("full_headaddr", pq.instr_address, 32'h0);
    checkOutput("full_headdata", pq.instr_data, 32'hA000_0000);

    applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, ON);
    checkOutput("pop_count", 32'(pq.count), 32'd3);
    checkOutput("pop_headaddr", pq.instr_address, 32'h4);
    checkOutput("pop_headdata", pq.instr_data, 32'hA000_0004);

    // Push and pop in the same cycle; tail wraps to entry 0.
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("pp_addr", 32'(pq.bus_address), 32'h4);
    applyStimulus(ON, ON, OFF, 32'hA000_0010, OFF, 32'h0, ON);
    checkOutput("pp_count", 32'(pq.count), 32'd3);
    checkOutput("pp_headaddr", pq.instr_address, 32'h8);

    applyStimulus(OFF, OFF, OFF, 32'h0, ON, 32'h0, OFF);
    checkOutput("jmp_flush_count", 32'(pq.count), 32'd0);
    checkOutput("jmp_flush_valid", 32'(pq.instr_valid), 32'd0);
    applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, ON);
    checkOutput("pop_empty", 32'(pq.count), 32'd0);

    // Streaming: ready held high, consumer takes whenever valid.
    expA = 32'h0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(ON, ON, OFF, 32'hB000_0000, OFF, 32'h0, ON);
      if (pq.instr_valid) begin
        checkOutput("stream_addr", pq.instr_address, expA);
        expA = expA + 32'd4;
        seen++;
      end
    end
    checkOutput("stream_seen", seen, 32'd4);

    // Jump while a read is outstanding, then again while discarding.
    applyStimulus(OFF, OFF, OFF, 32'h0, ON, 32'h8, OFF);
    checkOutput("mid_count0", 32'(pq.count), 32'd0);
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("mid_read", 32'(pq.bus_read), 32'd1);
    checkOutput("mid_addr8", 32'(pq.bus_address), 32'h2);
    applyStimulus(ON, OFF, OFF, 32'h0, ON, 32'h2000, OFF);
    checkOutput("disc_read", 32'(pq.bus_read), 32'd0);
    checkOutput("disc_addr", 32'(pq.bus_address), 32'h800);
    applyStimulus(ON, OFF, OFF, 32'h0, ON, 32'h1003, OFF);
    checkOutput("disc2_addr", 32'(pq.bus_address), 32'h400);
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("disc_hold", 32'(pq.bus_read), 32'd0);
    applyStimulus(ON, ON, OFF, 32'hDEAD_0008, OFF, 32'h0, OFF);
    checkOutput("disc_drop", 32'(pq.count), 32'd0);
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("post_jmp_read", 32'(pq.bus_read), 32'd1);
    checkOutput("post_jmp_addr", 32'(pq.bus_address), 32'h400);
    applyStimulus(ON, ON, OFF, 32'hC000_1000, OFF, 32'h0, OFF);
    checkOutput("post_jmp_iaddr", pq.instr_address, 32'h1000);
    checkOutput("post_jmp_idata", pq.instr_data, 32'hC000_1000);

    // Jump coincident with the completing read.
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("co_addr", 32'(pq.bus_address), 32'h401);
    applyStimulus(ON, ON, OFF, 32'hDEAD_1004, ON, 32'h300, OFF);
    checkOutput("co_count", 32'(pq.count), 32'd0);
    checkOutput("co_read", 32'(pq.bus_read), 32'd0);
    checkOutput("co_addr300", 32'(pq.bus_address), 32'hC0);

    // Grant withdrawn after the read starts.
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("gd_read", 32'(pq.bus_read), 32'd1);
    repeat (2) begin
      applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      checkOutput("gd_hold", 32'(pq.bus_read), 32'd1);
      checkOutput("gd_addr", 32'(pq.bus_address), 32'hC0);
    end
    applyStimulus(OFF, ON, OFF, 32'hE000_0300, OFF, 32'h0, OFF);
    checkOutput("gd_count", 32'(pq.count), 32'd1);
    checkOutput("gd_iaddr", pq.instr_address, 32'h300);
    checkOutput("gd_idata", pq.instr_data, 32'hE000_0300);
    repeat (2) begin
      applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      checkOutput("gd_noread", 32'(pq.bus_read), 32'd0);
    end

    // Bus error on the fetch at 0xC.
    applyStimulus(OFF, OFF, OFF, 32'h0, ON, 32'h0, OFF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      applyStimulus(ON, ON, OFF, 32'hF000_0000 + 4 * i, OFF, 32'h0, OFF);
    end
    checkOutput("err_pre_count", 32'(pq.count), 32'd3);
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("err_addr", 32'(pq.bus_address), 32'h3);
    applyStimulus(ON, ON, ON, 32'hBAD0_BAD0, OFF, 32'h0, OFF);
    checkOutput("err_fault", 32'(pq.fault), 32'd1);
    checkOutput("err_count", 32'(pq.count), 32'd3);
    repeat (2) begin
      applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      checkOutput("err_noread", 32'(pq.bus_read), 32'd0);
      checkOutput("err_pc_held", 32'(pq.bus_address), 32'h3);
    end
    applyStimulus(OFF, OFF, OFF, 32'h0, ON, 32'h40, OFF);
    checkOutput("err_clear", 32'(pq.fault), 32'd0);
    checkOutput("err_flush", 32'(pq.count), 32'd0);
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("err_resume_read", 32'(pq.bus_read), 32'd1);
    checkOutput("err_resume_addr", 32'(pq.bus_address), 32'h10);
    applyStimulus(ON, ON, OFF, 32'hF000_0040, OFF, 32'h0, OFF);
    checkOutput("err_resume_iaddr", pq.instr_address, 32'h40);

    // Fetch address wraps past the top of the address space.
    applyStimulus(OFF, OFF, OFF, 32'h0, ON, 32'hFFFF_FFF8, OFF);
    for (int i = 0; i < 3; i++) begin
      expA = 32'hFFFF_FFF8 + 32'(4 * i);
      applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
      checkOutput("wrap_busaddr", 32'(pq.bus_address), expA >> 2);
      applyStimulus(ON, ON, OFF, 32'h5000_0000 + i, OFF, 32'h0, OFF);
    end
    checkOutput("wrap_head0", pq.instr_address, 32'hFFFF_FFF8);
    applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, ON);
    checkOutput("wrap_head1", pq.instr_address, 32'hFFFF_FFFC);
    applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, ON);
    checkOutput("wrap_head2", pq.instr_address, 32'h0);
    checkOutput("wrap_data2", pq.instr_data, 32'h5000_0002);
    applyStimulus(OFF, OFF, OFF, 32'h0, OFF, 32'h0, ON);
    checkOutput("wrap_empty", 32'(pq.instr_valid), 32'd0);

    // Asynchronous reset in the middle of a read; a late ready must be ignored.
    applyStimulus(ON, OFF, OFF, 32'h0, OFF, 32'h0, OFF);
    checkOutput("ar_read", 32'(pq.bus_read), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("ar_async_read", 32'(pq.bus_read), 32'd0);
    checkOutput("ar_async_pc", 32'(pq.bus_address), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(OFF, ON, OFF, 32'hDEAD_BEEF, OFF, 32'h0, OFF);
    checkOutput("ar_ignore_ready", 32'(pq.count), 32'd0);
    checkOutput("ar_idle", 32'(pq.bus_read), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
